instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/imem_if.sv | 15 +
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
//   req   : read request, held until ack is sampled high
//   addr  : 16-bit word address of the outstanding read
//   ack   : rdata is valid for the current request
//   rdata : 32-bit instruction word
// master modport is the fetch side, slave modport is the memory side.
interface imem_if;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: keeps a single read outstanding on the instruction
// memory bus and presents each returned word, with its address, to decode.
// Redirects (taken branches/jumps) replace the PC; a request already in flight
// when a redirect arrives is completed and its data dropped.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   stall               : decode is holding the current instruction
//   redirect_valid/addr : PC change request and new word address
//   imem                : instruction memory bus (imem_if.master)
//   code/code_valid     : registered instruction word and its qualifier
//   pc_out              : word address of the instruction in code
//   fetch_err           : one-cycle watchdog timeout pulse (FETCH_TIMEOUT_EN)
//
// Build option: define FETCH_TIMEOUT_EN to add an 8-bit request watchdog and
// the fetch_err output; otherwise the unit waits for imem ack indefinitely.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_addr,
    imem_if.master      imem,
    output logic [31:0] code,
    output logic        code_valid,
    output logic [15:0] pc_out
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        fetch_err
`endif
);

    typedef enum logic [1:0] {S_REQ, S_DISCARD, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;         // next address to fetch
    logic [15:0] addr_q, addr_d;     // address of the request being discarded
    logic [31:0] code_q, code_d;
    logic        code_valid_q, code_valid_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        timeout;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0]  wdog_q, wdog_d;
    logic        fetch_err_q, fetch_err_d;

    always_comb begin
        timeout = 1'b0;
        wdog_d  = 8'd0;
        if (state_q != S_HOLD && !imem.ack) begin
            if (wdog_q == 8'(TIMEOUT - 1)) timeout = 1'b1;
            else                           wdog_d  = wdog_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        pc_out_d     = pc_out_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_addr;
                    // No ack yet: the old read must still complete, so keep
                    // its address on the bus and drop its data in DISCARD.
                    if (!imem.ack) begin
                        addr_d  = pc_q;
                        state_d = S_DISCARD;
                    end
                end else if (imem.ack) begin
                    code_d       = imem.rdata;
                    pc_out_d     = pc_q;
                    code_valid_d = 1'b1;
                    pc_d         = pc_q + 16'd1;
                    state_d      = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) pc_d = redirect_addr;
                if (imem.ack || timeout) state_d = S_REQ;
            end
            S_HOLD: begin
                // Redirect wins over stall: the held instruction is squashed.
                if (redirect_valid) begin
                    code_valid_d = 1'b0;
                    pc_d         = redirect_addr;
                    state_d      = S_REQ;
                end else if (!stall) begin
                    code_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err_d = timeout;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            code_q       <= 32'h0;
            code_valid_q <= 1'b0;
            pc_out_q     <= 16'h0;
`ifdef FETCH_TIMEOUT_EN
            wdog_q       <= 8'd0;
            fetch_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            pc_out_q     <= pc_out_d;
`ifdef FETCH_TIMEOUT_EN
            // Any state change restarts the watchdog.
            wdog_q       <= (state_d != state_q) ? 8'd0 : wdog_d;
            fetch_err_q  <= fetch_err_d;
`endif
        end
    end

    assign imem.req   = (state_q != S_HOLD);
    assign imem.addr  = (state_q == S_DISCARD) ? addr_q : pc_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign pc_out     = pc_out_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err  = fetch_err_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
`ifdef FETCH_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect_valid;
    logic [15:0] redirect_addr;
    logic [31:0] code;
    logic        code_valid;
    logic [15:0] pc_out;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif
    int n_cmp = 0;
    int n_err = 0;

    imem_if bus ();

    instruction_fetch #(.RESET_PC(16'h0000), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem(bus.master), .code(code), .code_valid(code_valid), .pc_out(pc_out)
`ifdef FETCH_TIMEOUT_EN
        , .fetch_err(fetch_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h1234;
        bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
        step(); step();
        n_cmp++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", code_valid); end
        n_cmp++; if (code !== 32'h0) begin n_err++; $display("FAIL rst_code got %h want 0", code); end
        n_cmp++; if (pc_out !== 16'h0) begin n_err++; $display("FAIL rst_pc_out got %h want 0", pc_out); end
        n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0000) begin
            n_err++; $display("FAIL rst_req got %b/%h want 1/0000", bus.req, bus.addr); end
    endtask

    // First fetch acked in the first cycle out of reset, then stalled.
    task automatic test_first_fetch_stall();
        rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        bus.ack = 1'b1; bus.rdata = 32'h0443_1000;
        step();
        n_cmp++; if (code_valid !== 1'b1 || code !== 32'h0443_1000 || pc_out !== 16'h0000) begin
            n_err++; $display("FAIL first_fetch got %b/%h/%h want 1/04431000/0000", code_valid, code, pc_out); end
        bus.ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (code_valid !== 1'b1 || code !== 32'h0443_1000 || pc_out !== 16'h0000 || bus.req !== 1'b0) begin
                n_err++; $display("FAIL stall_hold got %b/%h/%h/req%b want 1/04431000/0000/req0",
                                  code_valid, code, pc_out, bus.req); end
        end
        stall = 1'b0;
        step();
        n_cmp++; if (code_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 16'h0001) begin
            n_err++; $display("FAIL stall_release got %b/req%b/%h want 0/req1/0001", code_valid, bus.req, bus.addr); end
    endtask

    task automatic test_redirect_req();
        // Move PC to 0005 with a redirect that coincides with an ack (data dropped).
        redirect_valid = 1'b1; redirect_addr = 16'h0005; bus.ack = 1'b1; bus.rdata = 32'h1111_1111;
        step();
        n_cmp++; if (code_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 16'h0005) begin
            n_err++; $display("FAIL redir_ack got %b/req%b/%h want 0/req1/0005", code_valid, bus.req, bus.addr); end
        redirect_addr = 16'h0040; bus.ack = 1'b0;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0005) begin
                n_err++; $display("FAIL redir_wait got req%b/%h want req1/0005", bus.req, bus.addr); end
            if (i < 3) step();
        end
        bus.ack = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        step();
        n_cmp++; if (code_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 16'h0040) begin
            n_err++; $display("FAIL redir_drop got %b/req%b/%h want 0/req1/0040", code_valid, bus.req, bus.addr); end
        bus.rdata = mem(16'h0040);
        step();
        n_cmp++; if (code_valid !== 1'b1 || pc_out !== 16'h0040 || code !== mem(16'h0040)) begin
            n_err++; $display("FAIL redir_fetch got %b/%h/%h want 1/0040/%h", code_valid, pc_out, code, mem(16'h0040)); end
    endtask

    task automatic test_redirect_hold();
        stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0100; bus.ack = 1'b0;
        step();
        n_cmp++; if (code_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 16'h0100) begin
            n_err++; $display("FAIL redir_hold got %b/req%b/%h want 0/req1/0100", code_valid, bus.req, bus.addr); end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_addr = 16'hFFFF; bus.ack = 1'b1; bus.rdata = 32'h2222_2222;
        step();
        redirect_valid = 1'b0; bus.rdata = 32'hCAFE_F00D;
        step();
        n_cmp++; if (code_valid !== 1'b1 || pc_out !== 16'hFFFF || code !== 32'hCAFE_F00D) begin
            n_err++; $display("FAIL wrap_fetch got %b/%h/%h want 1/FFFF/CAFEF00D", code_valid, pc_out, code); end
        bus.ack = 1'b0;
        step();
        n_cmp++; if (code_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== 16'h0000) begin
            n_err++; $display("FAIL wrap_addr got %b/req%b/%h want 0/req1/0000", code_valid, bus.req, bus.addr); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        int first = -1;
        bus.ack = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (fetch_err === 1'b1) begin pulses++; if (first < 0) first = i; end
            n_cmp++; if (bus.req !== 1'b1 || bus.addr !== 16'h0000) begin
                n_err++; $display("FAIL tmo_req got req%b/%h want req1/0000", bus.req, bus.addr); end
        end
        n_cmp++; if (pulses !== 1 || first !== 4) begin
            n_err++; $display("FAIL tmo_pulse got %0d pulses first@%0d want 1 @4", pulses, first); end
    endtask
`endif

    // Random traffic against a stream model: delivered instructions must form
    // the sequential address stream, restarted at the latest redirect target.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic        red, cv0, st0, req0, ack0;
        logic [15:0] ra, pco0, addr0;
        logic [31:0] code0;
        int          nd = 0;
        // Re-synchronise the model with a reset.
        rst_n = 1'b0; redirect_valid = 1'b0; bus.ack = 1'b0;
        step();
        rst_n = 1'b1;
        exp_pc = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            stall          = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_addr  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                         : 16'($urandom);
            bus.ack        = ($urandom_range(0, 2) != 0);
            bus.rdata      = mem(bus.addr);
            red = redirect_valid; ra = redirect_addr; cv0 = code_valid; st0 = stall;
            code0 = code; pco0 = pc_out; req0 = bus.req; addr0 = bus.addr; ack0 = bus.ack;
            step();
            if (red) begin
                exp_pc = ra;
                n_cmp++; if (code_valid !== 1'b0) begin
                    n_err++; $display("FAIL rnd_redirect_valid cyc %0d got %b want 0", c, code_valid); end
            end else if (!cv0 && code_valid) begin
                n_cmp++; if (pc_out !== exp_pc || code !== mem(exp_pc)) begin
                    n_err++; $display("FAIL rnd_deliver cyc %0d got %h/%h want %h/%h", c, pc_out, code, exp_pc, mem(exp_pc)); end
                exp_pc = exp_pc + 16'd1;
                nd++;
            end else if (cv0 && st0) begin
                n_cmp++; if (code_valid !== 1'b1 || code !== code0 || pc_out !== pco0 || bus.req !== 1'b0) begin
                    n_err++; $display("FAIL rnd_stall cyc %0d got %b/%h/%h want 1/%h/%h", c, code_valid, code, pc_out, code0, pco0); end
            end else if (cv0) begin
                n_cmp++; if (code_valid !== 1'b0) begin
                    n_err++; $display("FAIL rnd_consume cyc %0d got %b want 0", c, code_valid); end
            end
            if (req0 && !ack0
`ifdef FETCH_TIMEOUT_EN
                && fetch_err !== 1'b1
`endif
               ) begin
                n_cmp++; if (bus.req !== 1'b1 || bus.addr !== addr0) begin
                    n_err++; $display("FAIL rnd_addr_stable cyc %0d got req%b/%h want req1/%h", c, bus.req, bus.addr, addr0); end
            end
        end
        n_cmp++; if (nd < 200) begin
            n_err++; $display("FAIL rnd_progress got %0d deliveries want >=200", nd); end
    endtask

    initial begin
        test_reset();
        test_first_fetch_stall();
        test_redirect_req();
        test_redirect_hold();
        test_wrap();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
